// File: rtl/leve1_fetch.sv
// Instruction fetch front end: credit-limited request issue, 2-entry in-order
// instruction queue, redirect with in-flight response discard.
// Optional performance counters are enabled with `define LEVE1_FETCH_PERF_EN.
module leve1_fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [31:0]     IMEM_RDATA,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [XLEN-1:0] OPC,
  output logic [31:0]     OINSTR
`ifdef LEVE1_FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] FETCH_CNT,
  output logic [XLEN-1:0] DISCARD_CNT
`endif
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      outst_q, outst_d;
  logic [1:0]      discard_q, discard_d;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] q_pc_q    [0:1];
  logic [XLEN-1:0] q_pc_d    [0:1];
  logic [31:0]     q_instr_q [0:1];
  logic [31:0]     q_instr_d [0:1];

  logic            active;
  logic            redir;
  logic            rsp;
  logic            grant;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] rsp_pc;

  // Low address bits of the redirect target are always forced to zero.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    q_pc_d    = q_pc_q;
    q_instr_d = q_instr_q;

    active    = !RST && (state_q != ST_BOOT);
    redir     = active && REDIRECT;
    rsp       = active && IMEM_RVALID;

    // Credit uses registered occupancy only, so a pop frees credit next cycle.
    IMEM_REQ  = !RST && (state_q == ST_FETCH) && !REDIRECT &&
                (({1'b0, outst_q} + {1'b0, count_q}) < 3'd2);
    IMEM_ADDR = pc_q;
    grant     = IMEM_REQ && IMEM_GNT;

    OVALID    = (count_q != 2'd0);
    OPC       = q_pc_q[rd_ptr_q];
    OINSTR    = q_instr_q[rd_ptr_q];
    pop       = OVALID && OREADY;

    push      = rsp && (state_q == ST_FETCH) && !REDIRECT && (outst_q != 2'd0);
    // Responses return in order, so the oldest live request sits outst_q words behind PC.
    rsp_pc    = pc_q - (XLEN'(outst_q) << 2);

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (redir) begin
          discard_d = outst_q - {1'b0, rsp && (outst_q != 2'd0)};
        end else begin
          if (grant) pc_d = pc_q + XLEN'(4);
          outst_d = outst_q + {1'b0, grant} - {1'b0, push};
          if (push) begin
            q_pc_d[wr_ptr_q]    = rsp_pc;
            q_instr_d[wr_ptr_q] = IMEM_RDATA;
            wr_ptr_d            = !wr_ptr_q;
          end
          if (pop) rd_ptr_d = !rd_ptr_q;
          count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
        state_d = (discard_d != 2'd0) ? ST_FLUSH : ST_FETCH;
      end
      ST_FLUSH: begin
        discard_d = discard_q - {1'b0, rsp && (discard_q != 2'd0)};
        state_d   = (discard_d != 2'd0) ? ST_FLUSH : ST_FETCH;
      end
      default: state_d = ST_BOOT;
    endcase

    if (redir) begin
      pc_d     = {REDIRECT_PC[XLEN-1:2], 2'b00};
      outst_d  = 2'd0;
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      outst_q   <= 2'd0;
      discard_q <= 2'd0;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      // NOTE: the queue storage is reset because OPC/OINSTR read it directly
      // and must show zero after reset; it is only two entries.
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      q_pc_q    <= q_pc_d;
      q_instr_q <= q_instr_d;
    end
  end

`ifdef LEVE1_FETCH_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] discard_cnt_q, discard_cnt_d;
  logic            drop;

  always_comb begin
    drop          = rsp && (redir || (state_q == ST_FLUSH));
    fetch_cnt_d   = fetch_cnt_q + XLEN'(pop);
    discard_cnt_d = discard_cnt_q + XLEN'(drop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      fetch_cnt_q   <= fetch_cnt_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  assign FETCH_CNT   = fetch_cnt_q;
  assign DISCARD_CNT = discard_cnt_q;
`endif

  // A response into a full queue is only legal when the head leaves the same cycle.
  assert property (@(posedge CLK) disable iff (RST)
    !(rsp && (state_q == ST_FETCH) && !REDIRECT && (count_q == 2'd2) && !pop));

endmodule
